// File: rtl/line_mem_ctrl_pkg.sv
// Shared definitions for the line memory, the cache controller and the cache:
// line geometry, controller states and request op encoding.
package line_mem_ctrl_pkg;

  localparam int LINE_BITS   = 128;
  localparam int OFFSET_BITS = 4;
  localparam int ADDR_BITS   = 32;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Caller guarantees exactly one of mem_read/mem_write is set.
  function automatic op_t decode_op(input logic mem_write);
    return mem_write ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/line_mem_ctrl_if.sv
// Request/completion bus between the cache controller (master) and the
// line memory controller (slave).
interface line_mem_ctrl_if
  import line_mem_ctrl_pkg::*;
;
  logic                 is_input_valid;
  logic [ADDR_BITS-1:0] addr;
  logic                 mem_read;
  logic                 mem_write;
  logic [LINE_BITS-1:0] din;
  logic                 mem_ready;
  logic                 is_output_valid;
  logic [LINE_BITS-1:0] dout;

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
    input  mem_ready, is_output_valid, dout
  );

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
    output mem_ready, is_output_valid, dout
  );

endinterface

// File: rtl/line_mem_array.sv
// Single-port backing store of 128-bit lines with a registered read port.
// Contents are never reset.
module line_mem_array
  import line_mem_ctrl_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int IDX_W     = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem [MEM_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Fixed-latency line memory controller: accepts one fill or write-back at a
// time and completes it DELAY cycles after acceptance with a one-cycle pulse.
module line_mem_ctrl
  import line_mem_ctrl_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int DELAY     = 50
) (
  input  logic           clk,
  input  logic           reset,
  line_mem_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_LINES);

  generate
    if (DELAY < 1 || DELAY > 255) begin : g_bad_delay
      $error("line_mem_ctrl: DELAY must be within 1..255");
    end
    if (MEM_LINES < 2 || (MEM_LINES & (MEM_LINES - 1)) != 0) begin : g_bad_lines
      $error("line_mem_ctrl: MEM_LINES must be a power of two >= 2");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  op_t                  op_q;
  logic [IDX_W-1:0]     idx_q;
  logic [LINE_BITS-1:0] din_q;
  logic [LINE_BITS-1:0] rd_data;
  logic [IDX_W-1:0]     req_idx;
  logic                 accept, commit, arr_we, arr_re;
  logic                 unused_addr_bits;

  // Upper address bits wrap silently; the byte offset is ignored.
  assign req_idx          = bus.addr[OFFSET_BITS +: IDX_W];
  assign unused_addr_bits = ^{bus.addr[ADDR_BITS-1:OFFSET_BITS+IDX_W],
                              bus.addr[OFFSET_BITS-1:0]};

  assign accept = (state_q == ST_IDLE) && bus.is_input_valid
                  && (bus.mem_read ^ bus.mem_write);
  // The array is touched only on the BUSY->DONE edge, and never under reset.
  assign commit = (state_q == ST_BUSY) && (cnt_q == '0) && !reset;
  assign arr_we = commit && (op_q == OP_WRITE);
  assign arr_re = commit && (op_q == OP_READ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= decode_op(bus.mem_write);
        idx_q <= req_idx;
        din_q <= bus.din;
        cnt_q <= CNT_W'(DELAY - 1);
      end else if (state_q == ST_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  line_mem_array #(
    .MEM_LINES (MEM_LINES),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx_q),
    .wdata (din_q),
    .rdata (rd_data)
  );

  assign bus.mem_ready       = (state_q == ST_IDLE);
  assign bus.is_output_valid = (state_q == ST_DONE);
  assign bus.dout            = (state_q == ST_DONE && op_q == OP_READ) ? rd_data : '0;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Scoreboard bench for line_mem_ctrl: expectations are queued at acceptance
// and retired against each completion pulse.
module tb_line_mem_ctrl;
  import line_mem_ctrl_pkg::*;

  localparam int MEM_LINES = 1024;
  localparam int DELAY     = 4;

  typedef struct {
    bit                   is_rd;
    logic [LINE_BITS-1:0] data;
    int                   idx;
    int                   acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t sb[$];
  logic [LINE_BITS-1:0] ref_mem [int];

  line_mem_ctrl_if bus ();

  line_mem_ctrl #(
    .MEM_LINES (MEM_LINES),
    .DELAY     (DELAY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LINE_BITS-1:0] obs,
                     input logic [LINE_BITS-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> OFFSET_BITS) % MEM_LINES);
  endfunction

  function automatic logic [LINE_BITS-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_idle();
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.addr           = '0;
    bus.din            = '0;
  endtask

  // Present a request, hold it until the controller is ready, then record
  // the expectation once the accepting edge has passed.
  task automatic issue(input bit is_rd, input logic [31:0] a,
                       input logic [LINE_BITS-1:0] d);
    exp_t e;
    int   n;
    bus.is_input_valid = 1'b1;
    bus.mem_read       = is_rd;
    bus.mem_write      = !is_rd;
    bus.addr           = a;
    bus.din            = d;
    n = 0;
    while (!bus.mem_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    @(negedge clk);
    e.is_rd = is_rd;
    e.idx   = line_of(a);
    e.acc   = cyc;
    e.data  = is_rd ? (ref_mem.exists(e.idx) ? ref_mem[e.idx] : '0) : d;
    sb.push_back(e);
    drive_idle();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && bus.mem_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 128'(sb.size()), 128'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.is_output_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 128'(1), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("latency", 128'(cyc - e.acc), 128'(DELAY));
          chk("ready_in_done", 128'(bus.mem_ready), 128'(0));
          if (e.is_rd) begin
            chk("rd_data", bus.dout, e.data);
          end else begin
            chk("wr_dout", bus.dout, '0);
            ref_mem[e.idx] = e.data;
          end
        end
      end else begin
        chk("dout_idle", bus.dout, '0);
      end
    end
  end

  initial begin
    int acc1;
    int busy;
    int n;
    logic [LINE_BITS-1:0] d4, d7, wd;
    cyc   = 0;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    drive_idle();
    d4 = rnd_line();
    d7 = rnd_line();

    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(bus.mem_ready), 128'(1));
    chk("rst_valid", 128'(bus.is_output_valid), 128'(0));
    chk("rst_dout", bus.dout, '0);
    reset = 1'b0;

    issue(1'b0, 32'h0000_0040, d4);
    wait_idle();
    issue(1'b0, 32'h0000_0070, d7);
    wait_idle();

    // Fill of line 4: ready stays low through BUSY, pulse DELAY edges later.
    issue(1'b1, 32'h0000_0040, '0);
    busy = 0;
    n = 0;
    while (!bus.is_output_valid && n < 100) begin
      if (!bus.mem_ready) busy++;
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", 128'(busy), 128'(DELAY));
    wait_idle();

    issue(1'b0, 32'h0000_0100, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    wait_idle();
    issue(1'b1, 32'h0000_010C, '0);
    wait_idle();

    issue(1'b1, 32'h0001_0040, '0);
    wait_idle();
    wd = rnd_line();
    issue(1'b0, 32'hFFFF_FF50, wd);
    wait_idle();
    issue(1'b1, 32'h0000_3F50, '0);
    wait_idle();

    for (int k = 0; k < 2; k++) begin
      bus.is_input_valid = 1'b1;
      bus.mem_read       = (k == 0);
      bus.mem_write      = (k == 0);
      bus.addr           = 32'h0000_0040;
      repeat (3) begin
        @(negedge clk);
        chk("bad_op_ready", 128'(bus.mem_ready), 128'(1));
      end
      drive_idle();
    end
    repeat (DELAY + 2) @(negedge clk);
    chk("bad_op_still_idle", 128'(bus.mem_ready), 128'(1));

    // A request held through BUSY lands on the first IDLE cycle (T+DELAY+1)
    // and is latched by that cycle's closing edge.
    issue(1'b1, 32'h0000_0040, '0);
    acc1 = cyc;
    issue(1'b1, 32'h0000_0070, '0);
    chk("held_accept_gap", 128'(cyc - acc1), 128'(DELAY + 2));
    wait_idle();

    issue(1'b0, 32'h0000_0040, rnd_line());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("abort_ready", 128'(bus.mem_ready), 128'(1));
    chk("abort_valid", 128'(bus.is_output_valid), 128'(0));
    chk("abort_dout", bus.dout, '0);
    repeat (DELAY + 2) @(negedge clk);
    chk("abort_idle", 128'(bus.mem_ready), 128'(1));
    issue(1'b1, 32'h0000_0040, '0);
    chk("abort_old_data_ref", ref_mem[4], d4);
    wait_idle();

    reset              = 1'b1;
    bus.is_input_valid = 1'b1;
    bus.mem_read       = 1'b1;
    bus.addr           = 32'h0000_0040;
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    chk("rst_prio_ready", 128'(bus.mem_ready), 128'(1));
    repeat (DELAY + 3) @(negedge clk);
    chk("rst_prio_idle", 128'(bus.mem_ready), 128'(1));

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = {18'(0), 10'($urandom_range(32, 63)), 4'(0)};
      issue(1'b0, a, rnd_line());
      wait_idle();
      a[3:0] = 4'($urandom_range(0, 15));
      issue(1'b1, a, '0);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
